keypad_emu: RTL and testbench

//  Behavioural-synthesizable model of a 4*4 matrix keypad, the far end of the row/col scan interface.

---
 rtl/keypad_emu.sv | 155 +++++++++++++++
 tb/tb_keypad_emu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emu.sv
// 4x4 matrix keypad emulator: answers active-low row strobes on col, key presses scheduled via valid/ready.
// Latency: col is registered, one clk after row/contact; contact and busy follow an accepted command by one clk.
// Backpressure: cmd_ready only while idle and out of reset. Define KEYPAD_EMU_BOUNCE_EN for LFSR contact chatter.
module keypad_emu #(
  parameter logic [15:0] BOUNCE_CYC = 16'd40,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        busy,
  output logic [15:0] contact
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BNC_DN = 2'd1,
    HOLD   = 2'd2,
    BNC_UP = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  key_q;
  logic [15:0] cnt;
  logic [15:0] key_oh;
  logic [3:0]  col_nxt;
  logic        accept;

  function automatic logic [15:0] onehot(input logic [3:0] k);
    return 16'h0001 << k;
  endfunction

  // A zero hold still closes the contact for one cycle.
  function automatic logic [15:0] hold_m1(input logic [15:0] h);
    return (h == 16'd0) ? 16'd0 : h - 16'd1;
  endfunction

  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign key_oh    = onehot(key_q);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] BNC_LEN = (BOUNCE_CYC == 16'd0) ? 16'd1 : BOUNCE_CYC;

  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [15:0] hold_q;

  // Fibonacci taps 8,6,5,4 shifting toward the MSB.
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

  always_comb begin
    col_nxt = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && contact[4*r+c]) col_nxt[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      contact <= 16'h0000;
      col     <= 4'hF;
      cnt     <= 16'd0;
      key_q   <= 4'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      lfsr    <= LFSR_SEED;
      hold_q  <= 16'd0;
`endif
    end else begin
      col <= col_nxt;
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (state != IDLE) lfsr <= lfsr_nxt;
`endif
      case (state)
        IDLE: begin
          contact <= 16'h0000;
          if (accept) begin
            key_q <= cmd_key;
            busy  <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            hold_q  <= cmd_hold;
            state   <= BNC_DN;
            cnt     <= BNC_LEN - 16'd1;
            contact <= onehot(cmd_key) & {16{lfsr[0]}};
`else
            state   <= HOLD;
            cnt     <= hold_m1(cmd_hold);
            contact <= onehot(cmd_key);
`endif
          end
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        BNC_DN: begin
          if (cnt == 16'd0) begin
            state   <= HOLD;
            cnt     <= hold_m1(hold_q);
            contact <= key_oh;
          end else begin
            cnt     <= cnt - 16'd1;
            contact <= key_oh & {16{lfsr_nxt[0]}};
          end
        end
`endif

        HOLD: begin
          if (cnt == 16'd0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            state   <= BNC_UP;
            cnt     <= BNC_LEN - 16'd1;
            contact <= key_oh & {16{lfsr_nxt[0]}};
`else
            state   <= IDLE;
            busy    <= 1'b0;
            contact <= 16'h0000;
`endif
          end else begin
            cnt     <= cnt - 16'd1;
            contact <= key_oh;
          end
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        BNC_UP: begin
          if (cnt == 16'd0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            contact <= 16'h0000;
          end else begin
            cnt     <= cnt - 16'd1;
            contact <= key_oh & {16{lfsr_nxt[0]}};
          end
        end
`endif

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          contact <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emu.sv
// Self-checking bench for keypad_emu: timed press windows and a row/col matrix model.
module tb_keypad_emu;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = 40;
`else
  localparam int BW = 0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic        busy;
  logic [15:0] contact;

  int vectors;
  int miscompares;

  keypad_emu #(.BOUNCE_CYC(16'd40), .LFSR_SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .busy      (busy),
    .contact   (contact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Keypad matrix: a closed key in a strobed row pulls its column low.
  function automatic logic [3:0] matrix(input logic [3:0] r, input logic [15:0] ct);
    logic [3:0] res;
    res = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (r[rr] == 1'b0 && ct[rr*4+cc] == 1'b1) res[cc] = 1'b0;
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete press: expected windows come from the sequence timing (bounce, hold, bounce).
  task automatic run_press(input string name, input logic [3:0] key, input logic [15:0] hold,
                           input logic [3:0] main_row, input bit rand_rows);
    int          hlen, total, w;
    logic [15:0] oh, exp_ct, prev_ct;
    logic [3:0]  prev_row, alt_row;
    bit          known, prev_known;
    bit          dn0, dn1, up0, up1;
    hlen  = (hold == 16'd0) ? 1 : int'(hold);
    total = 2*BW + hlen;
    oh    = 16'h0001 << key;
    alt_row = {main_row[2:0], main_row[3]};
    dn0 = 0; dn1 = 0; up0 = 0; up1 = 0;
    w = 0;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_timeout: cmd_ready=%b want 1", name, cmd_ready);
    end
    row = main_row;
    cmd_valid = 1'b1;
    cmd_key = key;
    cmd_hold = hold;
    tick();
    cmd_valid = 1'b0;
    cmd_key = 4'($urandom);
    cmd_hold = 16'($urandom);
    prev_row = main_row;
    prev_ct = 16'h0000;
    prev_known = 1;
    for (int s = 0; s < total + 2; s++) begin
      vectors++;
      if (busy !== (s < total)) begin
        miscompares++;
        $display("FAIL %s busy s=%0d: got %b want %b", name, s, busy, (s < total));
      end
      vectors++;
      if (cmd_ready !== (s >= total)) begin
        miscompares++;
        $display("FAIL %s cmd_ready s=%0d: got %b want %b", name, s, cmd_ready, (s >= total));
      end
      vectors++;
      if ((contact & ~oh) !== 16'h0000) begin
        miscompares++;
        $display("FAIL %s other_keys s=%0d: contact=%h want only bit %0d", name, s, contact, key);
      end
      if (s < BW) begin
        known = 0; exp_ct = 16'h0000;
        if (contact[key]) dn1 = 1; else dn0 = 1;
      end else if (s < BW + hlen) begin
        known = 1; exp_ct = oh;
      end else if (s < total) begin
        known = 0; exp_ct = 16'h0000;
        if (contact[key]) up1 = 1; else up0 = 1;
      end else begin
        known = 1; exp_ct = 16'h0000;
      end
      if (known) begin
        vectors++;
        if (contact !== exp_ct) begin
          miscompares++;
          $display("FAIL %s contact s=%0d: got %h want %h", name, s, contact, exp_ct);
        end
      end
      if (prev_known) begin
        vectors++;
        if (col !== matrix(prev_row, prev_ct)) begin
          miscompares++;
          $display("FAIL %s col s=%0d: got %b want %b", name, s, col, matrix(prev_row, prev_ct));
        end
      end
      prev_ct = exp_ct;
      prev_known = known;
      if (rand_rows) row = 4'($urandom_range(0, 15));
      else row = (s % 8 == 5) ? alt_row : main_row;
      prev_row = row;
      tick();
    end
    if (BW > 0) begin
      vectors++;
      if (!(dn0 && dn1 && up0 && up1)) begin
        miscompares++;
        $display("FAIL %s chatter: dn0=%b dn1=%b up0=%b up1=%b want all 1", name, dn0, dn1, up0, up1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    row = 4'b1110;
    cmd_valid = 1'b0;
    cmd_key = 4'd0;
    cmd_hold = 16'd0;
    tick();
    tick();
    vectors++;
    if (col !== 4'hF || contact !== 16'h0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: col=%h contact=%h busy=%b ready=%b want F 0000 0 0", col, contact, busy, cmd_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (col !== 4'hF || contact !== 16'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release c=%0d: col=%h contact=%h busy=%b ready=%b want F 0000 0 1",
                 i, col, contact, busy, cmd_ready);
      end
    end
  endtask

  task automatic test_clean_press();
    run_press("key6_hold100", 4'd6, 16'd100, 4'b1101, 0);
  endtask

  task automatic test_bounce();
    run_press("key15_hold50", 4'd15, 16'd50, 4'b0111, 0);
  endtask

  task automatic test_zero_hold();
    run_press("key9_hold0", 4'd9, 16'd0, 4'b1011, 0);
  endtask

  task automatic test_back_to_back();
    int total1, total2;
    total1 = 2*BW + 20;
    total2 = 2*BW + 5;
    row = 4'b1110;
    cmd_valid = 1'b1;
    cmd_key = 4'd3;
    cmd_hold = 16'd20;
    tick();
    cmd_hold = 16'd5;
    for (int s = 0; s < total1; s++) begin
      vectors++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_first s=%0d: busy=%b ready=%b want 1 0", s, busy, cmd_ready);
      end
      tick();
    end
    vectors++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || contact !== 16'h0) begin
      miscompares++;
      $display("FAIL b2b_gap: busy=%b ready=%b contact=%h want 0 1 0000", busy, cmd_ready, contact);
    end
    tick();
    cmd_valid = 1'b0;
    for (int s = 0; s < total2; s++) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_second_busy s=%0d: got %b want 1", s, busy);
      end
      if (s >= BW && s < BW + 5) begin
        vectors++;
        if (contact !== 16'h0008) begin
          miscompares++;
          $display("FAIL b2b_second_contact s=%0d: got %h want 0008", s, contact);
        end
      end
      tick();
    end
    vectors++;
    if (busy !== 1'b0 || contact !== 16'h0) begin
      miscompares++;
      $display("FAIL b2b_end: busy=%b contact=%h want 0 0000", busy, contact);
    end
  endtask

  task automatic test_reset_mid();
    row = 4'b1110;
    cmd_valid = 1'b1;
    cmd_key = 4'd0;
    cmd_hold = 16'd60;
    tick();
    cmd_valid = 1'b0;
    for (int s = 0; s < BW + 10; s++) tick();
    vectors++;
    if (contact !== 16'h0001 || col !== 4'b1110) begin
      miscompares++;
      $display("FAIL midhold: contact=%h col=%b want 0001 1110", contact, col);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (col !== 4'hF || contact !== 16'h0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset: col=%h contact=%h busy=%b ready=%b want F 0000 0 0", col, contact, busy, cmd_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (col !== 4'hF || contact !== 16'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL after_midreset c=%0d: col=%h contact=%h busy=%b ready=%b want F 0000 0 1",
                 i, col, contact, busy, cmd_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [3:0]  k;
      logic [15:0] h;
      logic [3:0]  r;
      k = 4'($urandom_range(0, 15));
      h = 16'($urandom_range(0, 30));
      r = 4'($urandom_range(0, 15));
      run_press("random", k, h, r, 1);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_zero_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
